// File: rtl/avalon_burst_mem_responder.sv
// Avalon-MM burst slave over on-chip RAM: pipelined write bursts, single-command read bursts.
// Optional `BURST_MEM_WAIT_INJECT_EN adds LFSR-driven waitrequest stalls in IDLE/WRITE.
module avalon_burst_mem_responder #(
   parameter int          WIDTHA    = 16,
   parameter int          WIDTHD    = 16,
   parameter int          WIDTHBE   = 2,
   parameter int          WIDTHB    = 9,
   parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
   input  logic               clock,
   input  logic               clock_sreset,
   input  logic [WIDTHA-1:0]  address,
   input  logic [WIDTHD-1:0]  writedata,
   input  logic [WIDTHBE-1:0] byteenable,
   input  logic [WIDTHB-1:0]  burstcount,
   input  logic               read,
   input  logic               write,
   output logic [WIDTHD-1:0]  readdata,
   output logic               readdatavalid,
   output logic               waitrequest
);

   localparam int AL    = $clog2(WIDTHBE);
   localparam int WA    = WIDTHA - AL;
   localparam int DEPTH = 2 ** WA;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_WRITE = 2'd1,
      S_READ  = 2'd2
   } state_t;

   state_t r_state;
   state_t w_next;

   logic [WIDTHD-1:0] r_mem [DEPTH];
   logic [WIDTHD-1:0] r_q;
   logic              r_q_vld;
   logic [WIDTHD-1:0] r_rdata;
   logic              r_rdv;
   logic [WA-1:0]     r_wr_addr;
   logic [WA-1:0]     r_rd_addr;
   logic [WIDTHB-1:0] r_rem;
   logic [WIDTHB-1:0] r_issue;
   logic [WIDTHB-1:0] r_beats;

   logic [WA-1:0]     w_word;
   logic [WIDTHB-1:0] w_bc;
   logic              w_rd_last;
   logic              w_idle_like;
   logic              w_acc;
   logic              w_acc_rd;
   logic              w_acc_wr;
   logic [WA-1:0]     w_waddr;
   logic [WA-1:0]     w_raddr;
   logic              w_stall;
   logic              w_unused;

   assign w_word   = address[WIDTHA-1:AL];
   assign w_bc     = (burstcount == '0) ? WIDTHB'(1) : burstcount;
   assign w_unused = ^{address[AL-1:0], LFSR_SEED};

`ifdef BURST_MEM_WAIT_INJECT_EN
   logic [15:0] r_lfsr;
   logic        w_fb;

   assign w_fb    = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
   assign w_stall = (r_lfsr[1:0] == 2'b00);

   always_ff @(posedge clock) begin
      if (clock_sreset) r_lfsr <= LFSR_SEED;
      else              r_lfsr <= {r_lfsr[14:0], w_fb};
   end
`else
   assign w_stall = 1'b0;
`endif

   // The last-beat cycle of a read behaves like IDLE for new commands
   assign w_rd_last   = (r_state == S_READ) & r_rdv & (r_beats == WIDTHB'(1));
   assign w_idle_like = (r_state == S_IDLE) | w_rd_last;

   assign w_acc    = (read | write) & ~waitrequest;
   assign w_acc_rd = w_acc & read & w_idle_like;
   assign w_acc_wr = w_acc & write & (w_idle_like | (r_state == S_WRITE));
   assign w_waddr  = w_idle_like ? w_word : r_wr_addr;
   assign w_raddr  = w_idle_like ? w_word : r_rd_addr;

   always_ff @(posedge clock) begin
      if (clock_sreset) r_state <= S_IDLE;
      else              r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_WRITE: begin
            if (w_acc_wr && r_rem == WIDTHB'(1)) w_next = S_IDLE;
         end
         S_IDLE, S_READ: begin
            if (w_idle_like) begin
               w_next = S_IDLE;
               if (w_acc_wr && w_bc != WIDTHB'(1)) w_next = S_WRITE;
               else if (w_acc_rd)                  w_next = S_READ;
            end
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_comb begin
      waitrequest = 1'b1;
      if (!clock_sreset) begin
         unique case (r_state)
            S_IDLE:  waitrequest = (read & write) | w_stall;
            S_WRITE: waitrequest = w_stall;
            S_READ:  waitrequest = ~w_rd_last | (read & write);
            default: waitrequest = 1'b1;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (w_acc_wr) begin
         for (int i = 0; i < WIDTHBE; i++) begin
            if (byteenable[i]) r_mem[w_waddr][8*i +: 8] <= writedata[8*i +: 8];
         end
      end
      r_q <= r_mem[w_raddr];
   end

   always_ff @(posedge clock) begin
      if (clock_sreset) begin
         r_wr_addr <= '0;
         r_rem     <= '0;
      end else if (w_acc_wr) begin
         r_wr_addr <= w_waddr + WA'(1);
         if (w_idle_like) r_rem <= w_bc - WIDTHB'(1);
         else             r_rem <= r_rem - WIDTHB'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (clock_sreset) begin
         r_q_vld   <= 1'b0;
         r_rdv     <= 1'b0;
         r_rdata   <= '0;
         r_rd_addr <= '0;
         r_issue   <= '0;
         r_beats   <= '0;
      end else begin
         r_rdv <= r_q_vld;
         if (r_q_vld) r_rdata <= r_q;
         if (r_rdv && r_beats != '0) r_beats <= r_beats - WIDTHB'(1);
         if (w_acc_rd) begin
            r_q_vld   <= 1'b1;
            r_rd_addr <= w_word + WA'(1);
            r_issue   <= w_bc - WIDTHB'(1);
            r_beats   <= w_bc;
         end else if (r_state == S_READ && r_issue != '0) begin
            r_q_vld   <= 1'b1;
            r_rd_addr <= r_rd_addr + WA'(1);
            r_issue   <= r_issue - WIDTHB'(1);
         end else begin
            r_q_vld   <= 1'b0;
         end
      end
   end

   assign readdata      = r_rdata;
   assign readdatavalid = r_rdv;

endmodule

// File: tb/tb_avalon_burst_mem_responder.sv
// Directed bench for avalon_burst_mem_responder: bursts, byte masks, wrap,
// long reads, mid-burst reset and read/write collision.
module tb_avalon_burst_mem_responder;

   logic        clock = 1'b0;
   logic        clock_sreset;
   logic [15:0] address;
   logic [15:0] writedata;
   logic [1:0]  byteenable;
   logic [8:0]  burstcount;
   logic        read;
   logic        write;
   logic [15:0] readdata;
   logic        readdatavalid;
   logic        waitrequest;

   int n_chk  = 0;
   int n_fail = 0;

   logic [15:0] d [8];
   logic [15:0] e [8];

   avalon_burst_mem_responder dut (
      .clock         (clock),
      .clock_sreset  (clock_sreset),
      .address       (address),
      .writedata     (writedata),
      .byteenable    (byteenable),
      .burstcount    (burstcount),
      .read          (read),
      .write         (write),
      .readdata      (readdata),
      .readdatavalid (readdatavalid),
      .waitrequest   (waitrequest)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // inputs already driven after a negedge; returns just after the accept edge
   task automatic wait_accept(input string tag);
      int t = 0;
      #1;
      while (waitrequest && t < 60) begin
         @(negedge clock);
         #1;
         t++;
      end
      if (t >= 60) check({tag, "_accept_timeout"}, 1, 0);
      @(posedge clock);
   endtask

   task automatic wr_burst(input logic [15:0] a, input logic [8:0] bc,
                           input int n, input logic [1:0] be);
      for (int k = 0; k < n; k++) begin
         @(negedge clock);
         write      = 1'b1;
         address    = a;
         burstcount = bc;
         writedata  = d[k];
         byteenable = be;
         wait_accept("wr");
      end
      @(negedge clock);
      write = 1'b0;
   endtask

   task automatic issue_read(input logic [15:0] a, input int bc);
      @(negedge clock);
      read       = 1'b1;
      address    = a;
      burstcount = bc[8:0];
      wait_accept("rd");
      @(negedge clock);
      read = 1'b0;
   endtask

   task automatic rd_burst(input logic [15:0] a, input int bc, input int nchk);
      int beat = 0;
      int wrh  = 0;
      int bad  = 0;
      issue_read(a, bc);
      for (int i = 0; i < bc + 10; i++) begin
         if (i > 0) @(negedge clock);
         if (waitrequest) wrh++;
         if (readdatavalid) begin
            if (beat < nchk) check("rd_data", readdata, e[beat]);
            if (i != beat + 1) bad++;
            if (beat == bc - 1) check("wr_low_last", waitrequest, 0);
            beat++;
         end
         if (beat == bc) break;
      end
      check("rd_slots", bad, 0);
      check("rd_beats", beat, bc);
      check("wr_high_cycles", wrh, bc);
      @(negedge clock);
      check("rdv_after", readdatavalid, 0);
      if (bc <= nchk) check("rd_hold", readdata, e[bc-1]);
   endtask

   initial begin
      int beat;
      clock_sreset = 1'b1;
      address      = '0;
      writedata    = '0;
      byteenable   = '0;
      burstcount   = '0;
      read         = 1'b0;
      write        = 1'b0;
      @(negedge clock);
      @(negedge clock);
      check("rst_wr", waitrequest, 1);
      check("rst_rdv", readdatavalid, 0);
      check("rst_rdata", readdata, 0);
      clock_sreset = 1'b0;
`ifndef BURST_MEM_WAIT_INJECT_EN
      #1;
      check("idle_wr", waitrequest, 0);
`endif

      d = '{16'h3F80, 16'h4000, 16'h4040, 16'h4080, 0, 0, 0, 0};
      wr_burst(16'h1000, 9'd4, 4, 2'b11);
      e = '{16'h3F80, 16'h4000, 16'h4040, 16'h4080, 0, 0, 0, 0};
      rd_burst(16'h1000, 4, 4);

      d[0] = 16'hFFFF;
      wr_burst(16'h2000, 9'd1, 1, 2'b11);
      d[0] = 16'h1234;
      wr_burst(16'h2000, 9'd1, 1, 2'b01);
      e[0] = 16'hFF34;
      rd_burst(16'h2000, 1, 1);

      d[0] = 16'hAAAA;
      d[1] = 16'h5555;
      wr_burst(16'hFFFE, 9'd2, 2, 2'b11);
      e[0] = 16'hAAAA;
      rd_burst(16'hFFFE, 1, 1);
      e[0] = 16'h5555;
      rd_burst(16'h0000, 1, 1);
      e[0] = 16'hAAAA;
      e[1] = 16'h5555;
      rd_burst(16'hFFFE, 2, 2);

      d[0] = 16'h1111;
      wr_burst(16'h3002, 9'd1, 1, 2'b11);
      d[0] = 16'hBEEF;
      wr_burst(16'h3000, 9'd0, 1, 2'b11);
      d[0] = 16'hCAFE;
      wr_burst(16'h3004, 9'd1, 1, 2'b11);
      e = '{16'hBEEF, 16'h1111, 16'hCAFE, 0, 0, 0, 0, 0};
      rd_burst(16'h3000, 3, 3);

      e[0] = 16'h5555;
      rd_burst(16'h0000, 256, 1);

      e = '{16'h3F80, 16'h4000, 16'h4040, 16'h4080, 0, 0, 0, 0};
      issue_read(16'h1000, 8);
      beat = 0;
      for (int i = 0; i < 20 && beat < 3; i++) begin
         if (i > 0) @(negedge clock);
         if (readdatavalid) begin
            check("rst_mid_data", readdata, e[beat]);
            beat++;
         end
      end
      check("rst_mid_beats", beat, 3);
      clock_sreset = 1'b1;
      @(negedge clock);
      check("rst_mid_rdv", readdatavalid, 0);
      check("rst_mid_wr", waitrequest, 1);
      @(negedge clock);
      clock_sreset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clock);
         check("rst_mid_quiet", readdatavalid, 0);
      end
      rd_burst(16'h1000, 4, 4);

      @(negedge clock);
      read       = 1'b1;
      write      = 1'b1;
      address    = 16'h2000;
      writedata  = 16'h0000;
      byteenable = 2'b11;
      burstcount = 9'd1;
      #1;
      check("coll_wr", waitrequest, 1);
      @(negedge clock);
      check("coll_rdv0", readdatavalid, 0);
      @(negedge clock);
      check("coll_rdv1", readdatavalid, 0);
      read  = 1'b0;
      write = 1'b0;
      e[0] = 16'hFF34;
      rd_burst(16'h2000, 1, 1);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
